// File: rtl/npu_seq_pkg.sv
// npu_seq_pkg
//   Shared types and defaults for the NPU layer sequencer.
//   - seq_state_e    : sequencer FSM states
//   - *_DEF          : default layer geometry and timeout
//   - WDOG_W         : watchdog counter width
package npu_seq_pkg;

   typedef enum logic [3:0] {
      IDLE,
      C1_RUN,
      C2_TRIG,
      C2_RUN,
      FC_START,
      FC_RD,
      FC_LD,
      FC_WAIT,
      FC_FIN
   } seq_state_e;

   localparam int unsigned C1_PIXELS_DEF   = 182;
   localparam int unsigned C2_PIXELS_DEF   = 132;
   localparam int unsigned CHAN_DEF        = 10;
   localparam int unsigned FC1_WORDS_DEF   = 330;
   localparam int unsigned WBUF_AW_DEF     = 9;
   localparam int unsigned TIMEOUT_CYC_DEF = 4096;

   localparam int unsigned WDOG_W = 16;

endpackage

// File: rtl/npu_layer_sequencer_if.sv
// npu_layer_sequencer_if
//   Bundles every sequencer signal except clock and reset.
//   Host side   : start, abort, busy, done, result, err_timeout
//   Conv engine : conv_trigger, conv_clear, conv_layer, ch_idx, conv_valid
//   Psum buffer : sum_clear
//   FC engine   : fcn_start, fcn_fc1_next, fcn_fc1_valid, fcn_done, fcn_logit, w_stream
//   Weight buf  : wbuf_re, wbuf_raddr, wbuf_rdata
//   master = sequencer, slave = surrounding datapath / host.
interface npu_layer_sequencer_if #(
   parameter int unsigned WBUF_AW = 9
) ();

   logic               start;
   logic               abort;
   logic               conv_trigger;
   logic               conv_clear;
   logic               conv_layer;
   logic [3:0]         ch_idx;
   logic               conv_valid;
   logic               sum_clear;
   logic               fcn_start;
   logic               fcn_fc1_next;
   logic               fcn_fc1_valid;
   logic               fcn_done;
   logic [23:0]        fcn_logit;
   logic               wbuf_re;
   logic [WBUF_AW-1:0] wbuf_raddr;
   logic [31:0]        wbuf_rdata;
   logic [31:0]        w_stream;
   logic               busy;
   logic               done;
   logic [23:0]        result;
   logic               err_timeout;

   modport master (
      input  start, abort, conv_valid, fcn_fc1_valid, fcn_done, fcn_logit, wbuf_rdata,
      output conv_trigger, conv_clear, conv_layer, ch_idx, sum_clear, fcn_start,
             fcn_fc1_next, wbuf_re, wbuf_raddr, w_stream, busy, done, result, err_timeout
   );

   modport slave (
      output start, abort, conv_valid, fcn_fc1_valid, fcn_done, fcn_logit, wbuf_rdata,
      input  conv_trigger, conv_clear, conv_layer, ch_idx, sum_clear, fcn_start,
             fcn_fc1_next, wbuf_re, wbuf_raddr, w_stream, busy, done, result, err_timeout
   );

endinterface

// File: rtl/npu_seq_watchdog.sv
// npu_seq_watchdog
//   Per-state cycle counter with a loadable limit.
//   clk, rst_ni : clock, async active-low reset
//   i_en        : counting enabled (sequencer not idle)
//   i_clear     : restart count (state change)
//   i_kick      : restart count (progress strobe)
//   i_limit     : number of cycles a state may last
//   o_expired   : high in the last allowed cycle
module npu_seq_watchdog #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_ni,
   input  logic         i_en,
   input  logic         i_clear,
   input  logic         i_kick,
   input  logic [W-1:0] i_limit,
   output logic         o_expired
);

   logic [W-1:0] r_cnt;

   assign o_expired = i_en && (r_cnt == (i_limit - W'(1)));

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt <= '0;
      end else if (i_clear || i_kick || !i_en) begin
         r_cnt <= '0;
      end else if (!o_expired) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

endmodule

// File: rtl/npu_layer_sequencer.sv
// npu_layer_sequencer
//   Runs conv1 once, conv2 once per channel, then streams FC1 weight words from the
//   weight buffer into the FC engine and captures the final logit.
//   clk, rst_ni : clock, async active-low reset
//   bus         : npu_layer_sequencer_if.master (host, conv, psum, FC, weight buffer)
module npu_layer_sequencer
   import npu_seq_pkg::*;
#(
   parameter int unsigned C1_PIXELS   = C1_PIXELS_DEF,
   parameter int unsigned C2_PIXELS   = C2_PIXELS_DEF,
   parameter int unsigned CHAN        = CHAN_DEF,
   parameter int unsigned FC1_WORDS   = FC1_WORDS_DEF,
   parameter int unsigned WBUF_AW     = WBUF_AW_DEF,
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input logic                   clk,
   input logic                   rst_ni,
   npu_layer_sequencer_if.master bus
);

   if ((FC1_WORDS > (2 ** WBUF_AW)) || (FC1_WORDS < 1) || (C1_PIXELS > 256) ||
       (C1_PIXELS < 1) || (C2_PIXELS > 256) || (C2_PIXELS < 1) || (CHAN > 16) ||
       (CHAN < 1) || (TIMEOUT_CYC < 2) || (TIMEOUT_CYC >= (2 ** WDOG_W))) begin : g_param_chk
      $error("npu_layer_sequencer: parameter out of range");
   end

   localparam logic [7:0]         C1_LAST    = 8'(C1_PIXELS - 1);
   localparam logic [7:0]         C2_LAST    = 8'(C2_PIXELS - 1);
   localparam logic [3:0]         CH_LAST    = 4'(CHAN - 1);
   localparam logic [WBUF_AW-1:0] K_LAST     = WBUF_AW'(FC1_WORDS - 1);
   localparam logic [WDOG_W-1:0]  WDOG_LIMIT = WDOG_W'(TIMEOUT_CYC);

   seq_state_e         r_state, w_state_nxt;
   logic [7:0]         r_pix, w_pix_nxt;
   logic [3:0]         r_ch, w_ch_nxt;
   logic [WBUF_AW-1:0] r_k, w_k_nxt;
   logic [31:0]        r_w_stream, w_w_stream_nxt;
   logic [23:0]        r_result, w_result_nxt;
   logic               r_layer, w_layer_nxt;
   logic               r_err, w_err_nxt;
   logic               r_trig, w_trig_nxt;
   logic               r_clr, w_clr_nxt;
   logic               r_sclr, w_sclr_nxt;
   logic               r_fst, w_fst_nxt;
   logic               r_next, w_next_nxt;
   logic               r_done, w_done_nxt;

   logic               w_active;
   logic               w_in_run;
   logic               w_expired;

   assign w_active = (r_state != IDLE);
   assign w_in_run = (r_state == C1_RUN) || (r_state == C2_RUN);

   npu_seq_watchdog #(
      .W (WDOG_W)
   ) u_watchdog (
      .clk       (clk),
      .rst_ni    (rst_ni),
      .i_en      (w_active),
      .i_clear   (w_state_nxt != r_state),
      .i_kick    (w_in_run && bus.conv_valid),
      .i_limit   (WDOG_LIMIT),
      .o_expired (w_expired)
   );

   always_comb begin
      w_state_nxt    = r_state;
      w_pix_nxt      = r_pix;
      w_ch_nxt       = r_ch;
      w_k_nxt        = r_k;
      w_w_stream_nxt = r_w_stream;
      w_result_nxt   = r_result;
      w_layer_nxt    = r_layer;
      w_err_nxt      = r_err;
      w_trig_nxt     = 1'b0;
      w_clr_nxt      = 1'b0;
      w_sclr_nxt     = 1'b0;
      w_fst_nxt      = 1'b0;
      w_next_nxt     = 1'b0;
      w_done_nxt     = 1'b0;

      // Abort beats everything, then the watchdog, then normal progress.
      if (w_active && bus.abort) begin
         w_state_nxt = IDLE;
         w_clr_nxt   = 1'b1;
      end else if (w_expired) begin
         w_state_nxt = IDLE;
         w_clr_nxt   = 1'b1;
         w_err_nxt   = 1'b1;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (bus.start) begin
                  w_state_nxt = C1_RUN;
                  w_trig_nxt  = 1'b1;
                  w_layer_nxt = 1'b0;
                  w_pix_nxt   = '0;
                  w_err_nxt   = 1'b0;
               end
            end
            C1_RUN: begin
               if (bus.conv_valid) begin
                  if (r_pix == C1_LAST) begin
                     w_state_nxt = C2_TRIG;
                     w_clr_nxt   = 1'b1;
                     w_layer_nxt = 1'b1;
                     w_sclr_nxt  = 1'b1;
                     w_ch_nxt    = '0;
                  end else begin
                     w_pix_nxt = r_pix + 8'd1;
                  end
               end
            end
            C2_TRIG: begin
               w_state_nxt = C2_RUN;
               w_trig_nxt  = 1'b1;
               w_pix_nxt   = '0;
            end
            C2_RUN: begin
               if (bus.conv_valid) begin
                  if (r_pix == C2_LAST) begin
                     w_clr_nxt = 1'b1;
                     if (r_ch == CH_LAST) begin
                        w_state_nxt = FC_START;
                     end else begin
                        w_ch_nxt    = r_ch + 4'd1;
                        w_state_nxt = C2_TRIG;
                     end
                  end else begin
                     w_pix_nxt = r_pix + 8'd1;
                  end
               end
            end
            FC_START: begin
               w_state_nxt = FC_RD;
               w_fst_nxt   = 1'b1;
               w_k_nxt     = '0;
            end
            FC_RD: begin
               w_state_nxt = FC_LD;
            end
            FC_LD: begin
               // Read data returns one cycle after wbuf_re, i.e. now.
               w_state_nxt    = FC_WAIT;
               w_w_stream_nxt = bus.wbuf_rdata;
            end
            FC_WAIT: begin
               if (bus.fcn_fc1_valid) begin
                  w_next_nxt = 1'b1;
                  if (r_k == K_LAST) begin
                     w_state_nxt = FC_FIN;
                  end else begin
                     w_k_nxt     = r_k + WBUF_AW'(1);
                     w_state_nxt = FC_RD;
                  end
               end
            end
            FC_FIN: begin
               if (bus.fcn_done) begin
                  w_state_nxt  = IDLE;
                  w_result_nxt = bus.fcn_logit;
                  w_done_nxt   = 1'b1;
               end
            end
            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= IDLE;
         r_pix      <= '0;
         r_ch       <= '0;
         r_k        <= '0;
         r_w_stream <= '0;
         r_result   <= '0;
         r_layer    <= 1'b0;
         r_err      <= 1'b0;
         r_trig     <= 1'b0;
         r_clr      <= 1'b0;
         r_sclr     <= 1'b0;
         r_fst      <= 1'b0;
         r_next     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pix      <= w_pix_nxt;
         r_ch       <= w_ch_nxt;
         r_k        <= w_k_nxt;
         r_w_stream <= w_w_stream_nxt;
         r_result   <= w_result_nxt;
         r_layer    <= w_layer_nxt;
         r_err      <= w_err_nxt;
         r_trig     <= w_trig_nxt;
         r_clr      <= w_clr_nxt;
         r_sclr     <= w_sclr_nxt;
         r_fst      <= w_fst_nxt;
         r_next     <= w_next_nxt;
         r_done     <= w_done_nxt;
      end
   end

   assign bus.conv_trigger = r_trig;
   assign bus.conv_clear   = r_clr;
   assign bus.conv_layer   = r_layer;
   assign bus.ch_idx       = r_ch;
   assign bus.sum_clear    = r_sclr;
   assign bus.fcn_start    = r_fst;
   assign bus.fcn_fc1_next = r_next;
   assign bus.wbuf_re      = (r_state == FC_RD);
   assign bus.wbuf_raddr   = r_k;
   assign bus.w_stream     = r_w_stream;
   assign bus.busy         = w_active;
   assign bus.done         = r_done;
   assign bus.result       = r_result;
   assign bus.err_timeout  = r_err;

endmodule

// File: tb/tb_npu_layer_sequencer.sv
// tb_npu_layer_sequencer
//   Table-driven full runs plus hand-written abort / timeout / reset sequences.
//   Expected weight words, read addresses and logits are queued when stimulus is
//   driven and popped when the DUT emits fcn_fc1_next, wbuf_re or done.
module tb_npu_layer_sequencer;

   localparam int unsigned AW = 9;
   localparam int unsigned NW = 3;

   typedef struct {
      logic [23:0]      logit;
      logic [2:0][31:0] w;
      int               hold;
   } run_t;

   logic clk    = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk = ~clk;

   npu_layer_sequencer_if #(.WBUF_AW(AW)) bus ();

   npu_layer_sequencer #(
      .C1_PIXELS   (4),
      .C2_PIXELS   (3),
      .CHAN        (2),
      .FC1_WORDS   (NW),
      .WBUF_AW     (AW),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk    (clk),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   logic [31:0] mem [4];

   always @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) bus.wbuf_rdata <= '0;
      else if (bus.wbuf_re) bus.wbuf_rdata <= mem[bus.wbuf_raddr[1:0]];
   end

   int n_chk = 0;
   int n_pass = 0;
   int cnt_trig, cnt_clr, cnt_sclr, cnt_fst, cnt_next, cnt_done;
   logic p_trig, p_clr, p_sclr, p_fst, p_next, p_done;
   logic [AW-1:0] q_addr [$];
   logic [31:0]   q_w [$];
   logic [23:0]   q_res [$];
   logic [23:0]   last_res;
   run_t          tbl [3];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", name, act, exp);
   endtask

   task automatic check_zero(input string name);
      check({name, "_ctl"}, {bus.busy, bus.done, bus.conv_trigger, bus.conv_clear,
                             bus.conv_layer, bus.ch_idx, bus.sum_clear, bus.fcn_start,
                             bus.fcn_fc1_next, bus.wbuf_re, bus.err_timeout}, 0);
      check({name, "_raddr"}, bus.wbuf_raddr, 0);
      check({name, "_wstream"}, bus.w_stream, 0);
      check({name, "_result"}, bus.result, 0);
   endtask

   // One cycle: sample at the falling edge, count pulses, drain the scoreboard.
   task automatic tick();
      @(negedge clk);
      if (bus.conv_trigger) begin check("trig_gap", p_trig, 0); cnt_trig++; end
      if (bus.conv_clear)   begin check("clr_gap",  p_clr,  0); cnt_clr++;  end
      if (bus.sum_clear)    begin check("sclr_gap", p_sclr, 0); cnt_sclr++; end
      if (bus.fcn_start)    begin check("fst_gap",  p_fst,  0); cnt_fst++;  end
      if (bus.fcn_fc1_next) begin check("next_gap", p_next, 0); cnt_next++; end
      if (bus.done)         begin check("done_gap", p_done, 0); cnt_done++; end
      p_trig = bus.conv_trigger; p_clr = bus.conv_clear; p_sclr = bus.sum_clear;
      p_fst = bus.fcn_start; p_next = bus.fcn_fc1_next; p_done = bus.done;
      if (bus.wbuf_re) begin
         check("raddr_expected", q_addr.size() > 0, 1);
         if (q_addr.size() > 0) check("wbuf_raddr", bus.wbuf_raddr, q_addr.pop_front());
      end
      if (bus.fcn_fc1_next) begin
         check("next_expected", q_w.size() > 0, 1);
         if (q_w.size() > 0) check("w_stream_at_next", bus.w_stream, q_w.pop_front());
      end
      if (bus.done) begin
         check("done_expected", q_res.size() > 0, 1);
         if (q_res.size() > 0) check("result_at_done", bus.result, q_res.pop_front());
         check("busy_at_done", bus.busy, 0);
      end
   endtask

   task automatic prep(input run_t r);
      cnt_trig = 0; cnt_clr = 0; cnt_sclr = 0; cnt_fst = 0; cnt_next = 0; cnt_done = 0;
      q_addr.delete(); q_w.delete(); q_res.delete();
      for (int i = 0; i < int'(NW); i++) begin
         mem[i] = r.w[i];
         q_addr.push_back(AW'(i));
         q_w.push_back(r.w[i]);
      end
      bus.fcn_logit = r.logit;
   endtask

   task automatic do_run(input run_t r);
      int  cd, hold_left, hold_j;
      bit  got;
      prep(r);
      bus.conv_valid    = 1'b1;
      bus.fcn_fc1_valid = 1'b1;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("busy_after_start", bus.busy, 1);
      cd = 0; hold_left = 0; hold_j = 0; got = 0;
      for (int c = 0; c < 300 && !got; c++) begin
         tick();
         bus.fcn_done = 1'b0;
         if (bus.done) got = 1;
         if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               bus.fcn_done = 1'b1;
               q_res.push_back(r.logit);
            end
         end
         if (hold_left > 0) begin
            hold_j++;
            if (hold_j >= 2) check("w_stream_held", bus.w_stream, r.w[1]);
            hold_left--;
            if (hold_left == 0) begin
               check("next_while_held", cnt_next, 1);
               bus.fcn_fc1_valid = 1'b1;
            end
         end
         if (bus.fcn_fc1_next) begin
            if (cnt_next == 1 && r.hold > 0) begin
               hold_left = r.hold; hold_j = 0; bus.fcn_fc1_valid = 1'b0;
            end
            if (cnt_next == int'(NW)) cd = 2;
         end
      end
      bus.fcn_done = 1'b0;
      check("run_done", got, 1);
      check("cnt_conv_trigger", cnt_trig, 3);
      check("cnt_conv_clear", cnt_clr, 3);
      check("cnt_sum_clear", cnt_sclr, 1);
      check("cnt_fcn_start", cnt_fst, 1);
      check("cnt_fc1_next", cnt_next, NW);
      check("cnt_done", cnt_done, 1);
      check("end_busy", bus.busy, 0);
      check("end_err", bus.err_timeout, 0);
      check("end_layer_ch", {bus.conv_layer, bus.ch_idx}, 5'h11);
      check("end_result", bus.result, r.logit);
      last_res = r.logit;
   endtask

   initial begin
      bit found;
      int n;

      tbl[0] = '{24'hFFFFFB, {32'h0C0B0A09, 32'h08070605, 32'h04030201}, 0};
      tbl[1] = '{24'h123456, {32'h89ABCDEF, 32'h01234567, 32'hDEADBEEF}, 10};
      tbl[2] = '{24'h800000, {32'hA5A5A5A5, 32'h00000000, 32'hFFFFFFFF}, 3};

      bus.start = 1'b0; bus.abort = 1'b0; bus.conv_valid = 1'b0;
      bus.fcn_fc1_valid = 1'b1; bus.fcn_done = 1'b0; bus.fcn_logit = '0;
      p_trig = 0; p_clr = 0; p_sclr = 0; p_fst = 0; p_next = 0; p_done = 0;
      for (int i = 0; i < 4; i++) mem[i] = '0;

      repeat (2) @(negedge clk);
      check_zero("reset");
      rst_ni = 1'b1;

      for (int i = 0; i < 3; i++) do_run(tbl[i]);

      // Abort in conv2 channel 1.
      prep('{24'h00002A, {32'h3, 32'h2, 32'h1}, 0});
      bus.conv_valid = 1'b1;
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      found = 0;
      for (int c = 0; c < 100 && !found; c++) begin
         tick();
         if (bus.conv_trigger && bus.conv_layer && bus.ch_idx == 4'd1) found = 1;
      end
      check("abort_reach_c2_ch1", found, 1);
      bus.abort = 1'b1; tick(); bus.abort = 1'b0;
      check("abort_busy", bus.busy, 0);
      check("abort_clear", bus.conv_clear, 1);
      check("abort_result", bus.result, last_res);
      repeat (4) tick();
      check("abort_no_done", cnt_done, 0);

      // Timeout with conv_valid stuck low.
      prep('{24'h0, {32'h0, 32'h0, 32'h0}, 0});
      bus.conv_valid = 1'b0;
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      n = 0;
      for (int c = 0; c < 40 && !bus.err_timeout; c++) begin
         tick();
         n++;
      end
      check("timeout_cycles", n, 16);
      check("timeout_clear", bus.conv_clear, 1);
      check("timeout_busy", bus.busy, 0);
      check("timeout_no_done", cnt_done, 0);
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      check("restart_clears_err", {bus.err_timeout, bus.busy}, 2'b01);
      bus.abort = 1'b1; tick(); bus.abort = 1'b0;
      check("restart_abort_busy", bus.busy, 0);

      // Start while busy, then abort colliding with fcn_done.
      prep('{24'h00000A, {32'h33, 32'h22, 32'h11}, 0});
      bus.conv_valid = 1'b1; bus.fcn_fc1_valid = 1'b1;
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      tick();
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      check("busy_start_ignored", {bus.conv_trigger, bus.busy}, 2'b01);
      for (int c = 0; c < 200 && cnt_next < int'(NW); c++) tick();
      check("collide_reach_fin", cnt_next, NW);
      tick(); tick();
      bus.fcn_done = 1'b1; bus.abort = 1'b1; bus.start = 1'b1;
      tick();
      bus.fcn_done = 1'b0; bus.abort = 1'b0; bus.start = 1'b0;
      check("collide_done", bus.done, 0);
      check("collide_busy", bus.busy, 0);
      check("collide_clear", bus.conv_clear, 1);
      check("collide_result", bus.result, last_res);
      tick();
      check("collide_idle", {bus.busy, bus.done}, 0);

      // Asynchronous reset while parked in FC_WAIT.
      prep(tbl[0]);
      bus.conv_valid = 1'b1; bus.fcn_fc1_valid = 1'b0;
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      found = 0;
      for (int c = 0; c < 100 && !found; c++) begin
         tick();
         if (bus.wbuf_re) found = 1;
      end
      check("rst_reach_fc", found, 1);
      tick(); tick();
      check("rst_w_loaded", bus.w_stream, tbl[0].w[0]);
      #2 rst_ni = 1'b0;
      #1 check_zero("async_reset");
      repeat (2) @(negedge clk);
      rst_ni = 1'b1;
      p_trig = 0; p_clr = 0; p_sclr = 0; p_fst = 0; p_next = 0; p_done = 0;
      do_run(tbl[0]);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/npu_layer_sequencer.md
Name: npu_layer_sequencer

Overview:
- Autonomous sequencer for the NPU inference datapath (conv engine, partial-sum buffer, FC engine).
- Replaces per-step host triggering: the host writes image and weights, pulses start, then polls busy/done/result.
- Runs conv1 once, conv2 once per channel, then streams FC1 weight words from the weight buffer into the FC engine.
- Captures the final logit.

Parameters:
- C1_PIXELS, 182, conv_valid pulses that complete conv1.
- C2_PIXELS, 132, conv_valid pulses that complete one conv2 channel pass.
- CHAN, 10, number of conv2 channel passes.
- FC1_WORDS, 330, 32-bit FC1 weight words (4 PEs x 8 bit) streamed per inference.
- WBUF_AW, 9, weight-buffer address width.
- TIMEOUT_CYC, 4096, maximum cycles any wait state may last.

Ports:
- clk  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle start request
- abort  in  1  one-cycle abort request
- conv_trigger  out  1  one-cycle conv pass trigger
- conv_clear  out  1  one-cycle conv address clear
- conv_layer  out  1  0 = conv1, 1 = conv2
- ch_idx  out  4  current conv2 channel
- conv_valid  in  1  conv engine pixel strobe
- sum_clear  out  1  one-cycle partial-sum clear
- fcn_start  out  1  one-cycle FC start
- fcn_fc1_next  out  1  one-cycle "w_stream holds the next group"
- fcn_fc1_valid  in  1  FC engine ready for the next group
- fcn_done  in  1  FC engine finished
- fcn_logit  in  24  signed result
- wbuf_re  out  1  weight-buffer read enable
- wbuf_raddr  out  WBUF_AW  weight-buffer read address
- wbuf_rdata  in  32  weight-buffer data, valid 1 cycle after wbuf_re
- w_stream  out  32  registered weights; byte p feeds PE p
- busy  out  1  high from the cycle after an accepted start until done/abort/error
- done  out  1  one-cycle completion pulse
- result  out  24  last logit, held
- err_timeout  out  1  sticky; cleared by the next accepted start

Behaviour:
- Reset (rst_ni low, asynchronous): state IDLE; all outputs and counters 0. Reset mid-operation abandons the run with no done.
- Pulse outputs (conv_trigger, conv_clear, sum_clear, fcn_start, fcn_fc1_next, done) are registered and never high for two consecutive cycles.
- IDLE: start -> C1_RUN. On the same edge: conv_layer=0, conv_trigger=1, pixel counter=0, err_timeout=0. start while busy is ignored.
- C1_RUN: count conv_valid. When the count reaches C1_PIXELS:
  - pulse conv_clear, set conv_layer=1, pulse sum_clear, ch=0;
  - go to C2_TRIG.
- C2_TRIG: pulse conv_trigger, counter=0 -> C2_RUN.
- C2_RUN: count conv_valid. At C2_PIXELS, pulse conv_clear, then:
  - if ch==CHAN-1 -> FC_START;
  - otherwise ch++ -> C2_TRIG.
  - ch_idx equals ch throughout.
- FC_START: pulse fcn_start, k=0 -> FC_RD.
- FC_RD: wbuf_re=1, wbuf_raddr=k -> FC_LD.
- FC_LD: w_stream <= wbuf_rdata -> FC_WAIT.
- FC_WAIT: when fcn_fc1_valid=1, pulse fcn_fc1_next.
  - if k==FC1_WORDS-1 -> FC_FIN;
  - otherwise k++ -> FC_RD.
  - If fcn_fc1_valid is already high on entry, fcn_fc1_next fires on the next edge. w_stream stays stable until the next FC_LD.
- FC_FIN: on fcn_done, result <= fcn_logit and pulse done -> IDLE. busy falls on the same edge as done.
- Timeout: a per-state cycle counter resets on every state change. It also resets on each conv_valid in C1_RUN/C2_RUN. When it reaches TIMEOUT_CYC:
  - set err_timeout, pulse conv_clear;
  - go to IDLE with no done.
- abort in any non-IDLE state: next state IDLE, pulse conv_clear, no done; result unchanged. abort has priority over every same-cycle event, including the final conv_valid or fcn_done.
- conv_valid arriving in a state other than C1_RUN/C2_RUN is ignored.
- Counter widths: pixel counter 8 bit, k WBUF_AW bit, ch 4 bit. FC1_WORDS must not exceed 2^WBUF_AW (elaboration assertion).

Decomposition:
- Package npu_seq_pkg holds:
  - the state enum (IDLE, C1_RUN, C2_TRIG, C2_RUN, FC_START, FC_RD, FC_LD, FC_WAIT, FC_FIN);
  - default pixel counts and the timeout constant.
- One sub-module, npu_seq_watchdog: a loadable cycle counter with clear/kick inputs and an expired output.

Test Plan:
- Full run with CHAN=2, C1_PIXELS=4, C2_PIXELS=3, FC1_WORDS=3, conv_valid every cycle, fcn_fc1_valid tied 1, fcn_done returned 2 cycles after the last fcn_fc1_next with logit -5:
  - conv_trigger count 3, conv_clear count 3, sum_clear count 1, fcn_fc1_next count 3, wbuf_raddr sequence 0,1,2;
  - done pulses once, result=24'hFFFFFB.
- Weight ordering: buffer words 0x04030201, 0x08070605 -> w_stream holds each value at its matching fcn_fc1_next. Holding fcn_fc1_valid low 10 cycles delays fcn_fc1_next with w_stream unchanged.
- Abort during C2_RUN with ch=1 -> IDLE next cycle, conv_clear pulse, busy=0, no done, result keeps its prior value.
- Timeout with TIMEOUT_CYC=16, conv_valid stuck low after trigger -> err_timeout=1 at cycle 16, IDLE; the next start clears err_timeout.
- start asserted while busy, and same-cycle abort + fcn_done -> start ignored; abort wins with no done.
- Assert rst_ni low mid FC_WAIT -> all outputs 0 asynchronously. A start after release runs a clean full sequence.
